// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. A request captures both operands, the mode and
// the carry/borrow-in, then one result bit is produced per clock, LSB first.
// The finished sum and final carry are published together on the last RUN
// edge and stay put until the next operation completes.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request; only looked at in IDLE
//   sub    in   1      0 = a + b + cin, 1 = a - b - cin
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   cin    in   1      carry-in (add) / borrow-in (sub)
//   s      out  WIDTH  registered result
//   cout   out  1      registered carry-out (add) / not-borrow (sub)
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle completion pulse
//
// Handshake: start is a level sampled on each rising edge while the FSM is
// in IDLE; a high sample accepts the request and all operand inputs on that
// same edge. There is no back-pressure: start seen in RUN or DONE is
// dropped. done is high for exactly one cycle, and s/cout are valid in that
// cycle and hold afterwards.
//
// Observability: the FSM register is the signal "state" (state_t), and the
// bit counter is "idx"; both are stable names for checkers to bind to.
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    // Bit index needs at least one bit even when WIDTH is 1.
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;      // already inverted for subtraction
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic             carry_next;
    logic             sum_bit;
    logic             last_bit;
    logic [IW-1:0]    idx;

    // One full-adder slice on the current LSBs of the operand shifters.
    always_comb begin
        sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last_bit   = (idx == LAST_IDX);
        // Sum bits are written in place at idx so the completed word is
        // available combinationally on the final RUN edge.
        sum_next      = sum_sr;
        sum_next[idx] = sum_bit;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and status outputs. busy and done decode distinct
    // states, so they can never be high together.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Operands are only loaded on acceptance, so input activity
    // during RUN/DONE cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            s      <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        // Subtraction as a + ~b + ~cin: borrow-in becomes
                        // an inverted carry-in, and cout reads as not-borrow.
                        b_sr   <= sub ? ~b : b;
                        carry  <= sub ? ~cin : cin;
                        sum_sr <= '0;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_next;
                    sum_sr <= sum_next;
                    idx    <= idx + IW'(1);
                    if (last_bit) begin
                        s    <= sum_next;
                        cout <= carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//
// Directed bench for serial_addsub. Two instances share the clock, reset and
// operand buses: u_dut8 (WIDTH=8) and u_dut1 (WIDTH=1, fed from bit 0 of the
// buses). Each has its own start so only one operates at a time.
// Every operation is checked for cycle-exact busy/done timing plus result.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       start8 = 1'b0;
    logic       start1 = 1'b0;
    logic       sub    = 1'b0;
    logic [7:0] a      = 8'h00;
    logic [7:0] b      = 8'h00;
    logic       cin    = 1'b0;

    logic [7:0] s8;
    logic       cout8, busy8, done8;
    logic [0:0] s1;
    logic       cout1, busy1, done1;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s8),
        .cout  (cout8),
        .busy  (busy8),
        .done  (done8)
    );

    serial_addsub #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .sub   (sub),
        .a     (a[0:0]),
        .b     (b[0:0]),
        .cin   (cin),
        .s     (s1),
        .cout  (cout1),
        .busy  (busy1),
        .done  (done1)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive start into the selected instance.
    task automatic set_start(input bit sel, input logic v);
        if (sel) start1 = v;
        else     start8 = v;
    endtask

    // One operation: start is presented in the cycle before edge k; samples
    // are taken on falling edges, so sample j lies in cycle k+j.
    // glitch_at > 0 re-asserts start (with all-ones operands) during that
    // cycle to confirm it is ignored. Operands are scrambled after accept.
    task automatic run_op(input bit sel, input string tag,
                          input logic sub_i, input logic [7:0] a_i,
                          input logic [7:0] b_i, input logic cin_i,
                          input logic [7:0] exp_s, input logic exp_c,
                          input int glitch_at);
        int w;
        int busy_cnt;
        logic o_busy, o_done, o_cout;
        logic [7:0] o_s;
        w = sel ? 1 : 8;
        busy_cnt = 0;
        @(negedge clk);
        sub = sub_i; a = a_i; b = b_i; cin = cin_i;
        set_start(sel, 1'b1);
        for (int j = 1; j <= w + 1; j++) begin
            @(negedge clk);
            o_busy = sel ? busy1 : busy8;
            o_done = sel ? done1 : done8;
            o_cout = sel ? cout1 : cout8;
            o_s    = sel ? {7'd0, s1} : s8;
            if (j <= w) begin
                if (o_busy && !o_done) busy_cnt++;
            end else begin
                check({tag, "_busy_cycles"}, busy_cnt, w);
                check({tag, "_done"}, o_done, 1'b1);
                check({tag, "_busy_in_done"}, o_busy, 1'b0);
                check({tag, "_s"}, o_s, exp_s);
                check({tag, "_cout"}, o_cout, exp_c);
            end
            set_start(sel, 1'b0);
            if (j == 1) begin
                a   = 8'($urandom_range(0, 255));
                b   = 8'($urandom_range(0, 255));
                sub = 1'($urandom_range(0, 1));
                cin = 1'($urandom_range(0, 1));
            end
            if (j == glitch_at) begin
                a = 8'hFF; b = 8'hFF;
                set_start(sel, 1'b1);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state, then release just after a rising edge.
        #2;
        check("rst_s", s8, 8'h00);
        check("rst_cout", cout8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_w1_out", {s1, cout1, busy1, done1}, 4'b0000);
        @(posedge clk); #1 rst = 1'b0;

        // WIDTH=8 directed vectors (back to back at the minimum period).
        run_op(0, "add_00_00",   0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        run_op(0, "add_ff_01",   0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
        run_op(0, "add_aa_55_c", 0, 8'hAA, 8'h55, 1, 8'h00, 1, 0);
        run_op(0, "sub_05_07",   1, 8'h05, 8'h07, 0, 8'hFE, 0, 0);
        run_op(0, "sub_07_05_b", 1, 8'h07, 8'h05, 1, 8'h01, 1, 0);
        run_op(0, "add_7f_01",   0, 8'h7F, 8'h01, 0, 8'h80, 0, 0);
        run_op(0, "sub_00_00",   1, 8'h00, 8'h00, 0, 8'h00, 1, 0);
        run_op(0, "add_10_20_ig",0, 8'h10, 8'h20, 0, 8'h30, 0, 3);
        run_op(0, "sub_00_01",   1, 8'h00, 8'h01, 0, 8'hFF, 0, 0);

        // Abort in the 4th RUN cycle: outputs clear at once, no done.
        @(negedge clk);
        sub = 1'b0; a = 8'h33; b = 8'h44; cin = 1'b0;
        start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;        // RUN cycle 1
        @(negedge clk);                       // RUN cycle 2
        @(negedge clk);                       // RUN cycle 3
        @(negedge clk);                       // RUN cycle 4
        check("abort_busy_before", busy8, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_s", s8, 8'h00);
        check("abort_cout", cout8, 1'b0);
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        @(negedge clk);
        check("abort_hold_done", done8, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        run_op(0, "post_rst_01_01", 0, 8'h01, 8'h01, 0, 8'h02, 0, 0);
        @(negedge clk);
        check("post_rst_done_off", done8, 1'b0);

        // WIDTH=1: all eight add combinations, {cout,s} = a+b+cin.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] sum2;
            v    = 3'(i);
            sum2 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
            run_op(1, $sformatf("w1_add_%0d", i), 0, {7'd0, v[2]}, {7'd0, v[1]},
                   v[0], {7'd0, sum2[0]}, sum2[1], 0);
        end
        // WIDTH=1 subtract: 0 - 1 - 0 -> s=1 with borrow (cout=0).
        run_op(1, "w1_sub_0_1", 1, 8'h00, 8'h01, 0, 8'h01, 0, 0);
        @(negedge clk);
        check("w1_done_off", done1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
